eq_band_mixer: RTL and testbench
================================

// Module: eq_band_mixer
// PURPOSE
//   Downstream of the per-band scalers. Captures NUM_BANDS saturated, pot-scaled signed 16-bit band samples on a strobe.
//   Sums them serially, one band per clock, in a guard-widened accumulator and saturates the sum to 16 bits.
//   Applies a 12-bit master volume and emits one mixed sample with a single-cycle valid pulse toward the DAC/output path.
// PARAMETERS
//   NUM_BANDS  5  number of band inputs summed; legal range 2..8 (3 guard bits)
// PORTS
//   clk        in   1               system clock, all state on rising edge
//   rst_n      in   1               asynchronous active-low reset
//   smpl_vld   in   1               one-cycle strobe: band_in stable and valid this cycle
//   band_in    in   16*NUM_BANDS    packed signed band samples; band k at [16k+15:16k]
//   volume     in   12              unsigned master volume, Q0.12 (12'hFFF = 4095/4096)
//   mix_out    out  16              signed mixed sample; held between updates
//   mix_vld    out  1               one-cycle pulse when mix_out updates
//   busy       out  1               high whenever state != IDLE
//   overrun    out  1               sticky: smpl_vld arrived while busy; cleared only by reset
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, acc=0, idx=0, shadow regs=0, mix_out=16'h0000, mix_vld=0, busy=0, overrun=0.
//   Reset mid-operation aborts the sample; no mix_vld is produced for it.
//   FSM states IDLE -> ACCUM -> SAT -> SCALE -> IDLE.
//   - IDLE: on smpl_vld, copy band_in into shadow regs, clear acc and idx, go to ACCUM.
//   - ACCUM: acc <= acc + sext19(shadow[idx]); idx++. After the NUM_BANDS-th add, go to SAT.
//   - SAT: acc > 32767 -> 16'h7FFF; acc < -32768 -> 16'h8000; else acc[15:0]. Register the result as sat_sum and go to SCALE.
//   - SCALE: prod(29b) = sat_sum * $signed({1'b0,volume}). mix_out <= prod[27:12] (arithmetic >>12, floor toward -inf).
//     mix_vld <= 1 for exactly one cycle; go to IDLE.
//   - volume is sampled only at the SCALE edge; band_in is sampled only at the capture edge.
//   Arithmetic rules:
//   - acc is 19-bit signed. No intermediate saturation; only the final sum is clamped.
//   - |prod| < 2^27, so the output stage cannot overflow.
//   Latency: smpl_vld sampled at edge E0 -> mix_out/mix_vld valid after edge E0+NUM_BANDS+2 (7 for default).
//   Throughput: next smpl_vld accepted in the cycle mix_vld is high (state already IDLE) -> one sample per NUM_BANDS+3 clocks.
//   smpl_vld while busy: ignored (no recapture, no restart), overrun <= 1. The in-flight sample completes normally.
//   mix_vld never asserts without a preceding accepted smpl_vld; never two consecutive cycles.
// TESTING
//   1 Reset mid-ACCUM:
//     - assert rst_n=0 with all bands 16'h1234 in flight -> mix_out=0, mix_vld=0, busy=0 immediately (async);
//     - no mix_vld after release.
//   2 All bands 16'h1000, volume 12'hFFF, single smpl_vld -> mix_vld exactly 7 edges later, mix_out=16'h4FFB (20480*4095>>12).
//   3 All bands 16'h7FFF, volume 12'hFFF -> sum clamps to 16'h7FFF, mix_out=16'h7FF7.
//     All bands 16'h8000, volume 12'h800 -> clamp 16'h8000, mix_out=16'hC000.
//   4 Bands {7FFF,7FFF,8000,8000,0005}, volume 12'hFFF -> no clamp (sum=3), mix_out=16'h0002.
//     Bands summing to -1, volume 12'hFFF -> mix_out=16'hFFFF (floor). Any bands, volume 0 -> mix_out=0.
//   5 Second smpl_vld 3 cycles after the first -> ignored, overrun=1 and stays 1, exactly one mix_vld with the first sample's result.
//     smpl_vld in the mix_vld cycle -> accepted, overrun unchanged.
//   6 Change volume from 12'h000 to 12'hFFF at the ACCUM->SAT edge (bands 16'h1000) -> result uses 12'hFFF (16'h4FFB).
//     Changing band_in after capture has no effect.

Source files
------------

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: serial band summer with output clamp and master volume.
// One mixed sample per NUM_BANDS+3 clocks, single-cycle valid toward the DAC.
module eq_band_mixer #(
  parameter int NUM_BANDS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    smpl_vld,
  input  logic [16*NUM_BANDS-1:0] band_in,
  input  logic [11:0]             volume,
  output logic [15:0]             mix_out,
  output logic                    mix_vld,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT,
    SCALE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [15:0] shadow [NUM_BANDS];
  logic [IW-1:0]      idx;
  logic signed [18:0] acc;
  logic signed [15:0] sat_sum;
  logic signed [28:0] prod;
  logic               last;
  logic               unused_prod;

  assign last = (idx == IW'(NUM_BANDS - 1));
  assign busy = (state != IDLE);

  // Volume is a non-negative Q0.12 gain, so it gets a zero sign bit.
  assign prod = sat_sum * $signed({1'b0, volume});

  // Top bit is redundant (|prod| < 2^27), low bits are the dropped fraction.
  assign unused_prod = ^{prod[28], prod[11:0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: capture, one add per band, clamp, scale, back to idle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (smpl_vld) state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = SAT;
      SAT:     state_nxt = SCALE;
      SCALE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shadow capture, accumulation, clamp and volume scaling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        shadow[k] <= '0;
      end
      idx     <= '0;
      acc     <= '0;
      sat_sum <= '0;
      mix_out <= '0;
      mix_vld <= 1'b0;
    end else begin
      mix_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (smpl_vld) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
              shadow[k] <= band_in[16*k +: 16];
            end
            idx <= '0;
            acc <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + $signed({{3{shadow[idx][15]}}, shadow[idx]});
          idx <= idx + IW'(1);
        end
        SAT: begin
          if (acc > 19'sd32767) begin
            sat_sum <= 16'sh7FFF;
          end else if (acc < -19'sd32768) begin
            sat_sum <= 16'sh8000;
          end else begin
            sat_sum <= acc[15:0];
          end
        end
        SCALE: begin
          mix_out <= prod[27:12];
          mix_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky flag: a strobe arrived while a sample was still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (smpl_vld && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer: vector table, random vs. arithmetic model,
// and hand sequences for reset, overrun and sampling-edge cases.
module tb_eq_band_mixer;

  localparam int NB = 5;
  localparam int WB = 16 * NB;

  logic          clk;
  logic          rst_n;
  logic          smpl_vld;
  logic [WB-1:0] band_in;
  logic [11:0]   volume;
  logic [15:0]   mix_out;
  logic          mix_vld;
  logic          busy;
  logic          overrun;

  int n_chk;
  int n_fail;

  eq_band_mixer #(.NUM_BANDS(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .smpl_vld (smpl_vld),
    .band_in  (band_in),
    .volume   (volume),
    .mix_out  (mix_out),
    .mix_vld  (mix_vld),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string         name;
    logic [WB-1:0] bands;
    logic [11:0]   vol;
    logic [15:0]   exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WB-1:0] rep(input logic [15:0] x);
    return {NB{x}};
  endfunction

  // Reference: integer sum, clamp to int16, multiply, floor-divide by 4096.
  function automatic logic [15:0] model(input logic [WB-1:0] b,
                                        input logic [11:0] v);
    longint s;
    longint p;
    logic [15:0] r;
    s = 0;
    for (int k = 0; k < NB; k++) begin
      s += longint'($signed(b[16*k +: 16]));
    end
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    p = s * longint'({20'd0, v});
    if (p >= 0) p = p / 4096;
    else p = -((-p + 4095) / 4096);
    r = p[15:0];
    return r;
  endfunction

  task automatic wait_vld(output logic [15:0] res, output int lat);
    lat = -1;
    res = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (mix_vld) begin
        lat = n;
        res = mix_out;
        break;
      end
    end
  endtask

  task automatic run_sample(input logic [WB-1:0] b, input logic [11:0] v,
                            output logic [15:0] res, output int lat);
    @(negedge clk);
    band_in  = b;
    volume   = v;
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    wait_vld(res, lat);
    @(posedge clk);
    #1;
    chk("vld_single_pulse", {31'd0, mix_vld}, 32'd0);
  endtask

  logic [15:0]   res;
  logic [15:0]   first_val;
  logic [WB-1:0] rb;
  logic [11:0]   rv;
  int            lat;
  int            pulses;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    smpl_vld = 1'b0;
    band_in  = '0;
    volume   = '0;

    vecs[0] = '{"sum_20480",  rep(16'h1000), 12'hFFF, 16'h4FFB};
    vecs[1] = '{"clamp_pos",  rep(16'h7FFF), 12'hFFF, 16'h7FF7};
    vecs[2] = '{"clamp_neg",  rep(16'h8000), 12'h800, 16'hC000};
    vecs[3] = '{"no_clamp_3",
                {16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0005},
                12'hFFF, 16'h0002};
    vecs[4] = '{"floor_m1",
                {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF},
                12'hFFF, 16'hFFFF};
    vecs[5] = '{"vol_zero",   rep(16'h1234), 12'h000, 16'h0000};
    vecs[6] = '{"neg_noclamp", rep(16'hF000), 12'h400, 16'hEC00};

    #12;
    chk("rst_mix_out", {16'd0, mix_out}, 32'd0);
    chk("rst_mix_vld", {31'd0, mix_vld}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_sample(vecs[i].bands, vecs[i].vol, res, lat);
      chk(vecs[i].name, {16'd0, res}, {16'd0, vecs[i].exp});
      chk("latency", lat, 7);
    end

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < NB; k++) begin
        if (i % 3 == 0) begin
          rb[16*k +: 16] = 16'($urandom_range(0, 4000)) - 16'd2000;
        end else begin
          rb[16*k +: 16] = 16'($urandom);
        end
      end
      rv = 12'($urandom);
      run_sample(rb, rv, res, lat);
      chk("random_mix", {16'd0, res}, {16'd0, model(rb, rv)});
      chk("random_latency", lat, 7);
    end
    chk("overrun_idle", {31'd0, overrun}, 32'd0);

    // Strobe during the mix_vld cycle is accepted without overrun.
    @(negedge clk);
    band_in  = rep(16'h1000);
    volume   = 12'hFFF;
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    wait_vld(res, lat);
    chk("b2b_first", {16'd0, res}, 32'h4FFB);
    band_in  = rep(16'h0100);
    volume   = 12'h800;
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    chk("b2b_vld_drop", {31'd0, mix_vld}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_vld(res, lat);
    chk("b2b_second", {16'd0, res},
        {16'd0, model(rep(16'h0100), 12'h800)});
    chk("b2b_latency", lat, 7);
    chk("b2b_overrun", {31'd0, overrun}, 32'd0);

    // Second strobe three cycles in is ignored and flags overrun.
    @(negedge clk);
    band_in  = rep(16'h1000);
    volume   = 12'hFFF;
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    band_in  = rep(16'h7FFF);
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    pulses    = 0;
    first_val = '0;
    lat       = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (mix_vld) begin
        if (pulses == 0) begin
          first_val = mix_out;
          lat = n;
        end
        pulses++;
      end
    end
    chk("overrun_pulses", pulses, 1);
    chk("overrun_result", {16'd0, first_val}, 32'h4FFB);
    chk("overrun_latency", lat, 4);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Volume taken at the scale edge; band_in only at capture.
    @(negedge clk);
    band_in  = rep(16'h1000);
    volume   = 12'h000;
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    band_in  = rep(16'h7FFF);
    repeat (5) @(posedge clk);
    #1;
    volume = 12'hFFF;
    wait_vld(res, lat);
    chk("late_volume", {16'd0, res}, 32'h4FFB);
    chk("late_volume_lat", lat, 2);

    // Reset mid-accumulation aborts the sample.
    @(negedge clk);
    band_in  = rep(16'h1234);
    volume   = 12'hFFF;
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mix_out", {16'd0, mix_out}, 32'd0);
    chk("arst_mix_vld", {31'd0, mix_vld}, 32'd0);
    chk("arst_busy",    {31'd0, busy},    32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (mix_vld) pulses++;
    end
    chk("arst_no_vld", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
